// File: rtl/flopenr_pkg.sv
// Shared sizing constants and helpers for the flopenr register family.
// Optional synchronous clear is enabled with FLOPENR_SCLR_EN.
package flopenr_pkg;

    localparam int FLOPENR_DEFAULT_WIDTH = 1;
    localparam int FLOPENR_MAX_WIDTH     = 64;

    // Keep only the low 'width' bits of a reset constant.
    function automatic logic [FLOPENR_MAX_WIDTH-1:0] fit_reset(
        input logic [FLOPENR_MAX_WIDTH-1:0] value,
        input int                           width
    );
        logic [FLOPENR_MAX_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < FLOPENR_MAX_WIDTH; i++) begin
            if (i < width) mask[i] = 1'b1;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/flopenr_bit.sv
// One-bit flop cell: synchronous reset, optional synchronous clear, load enable.
// Optional sclr input is present when FLOPENR_SCLR_EN is defined.
module flopenr_bit (
    input  logic reset,
    input  logic clk,
    input  logic d,
    input  logic e,
    input  logic rv,
    output logic q
`ifdef FLOPENR_SCLR_EN
    ,
    input  logic sclr
`endif
);

    // Ternary hold path lets an unknown enable propagate X instead of masking it.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= rv;
`ifdef FLOPENR_SCLR_EN
        end else if (sclr) begin
            q <= rv;
`endif
        end else begin
            q <= e ? d : q;
        end
    end

endmodule

// File: rtl/flopenr_reg.sv
// Parameterised enable register with synchronous active-high reset.
// Defining FLOPENR_SCLR_EN adds a trailing sclr input (reset > sclr > E).
module flopenr_reg
    import flopenr_pkg::*;
#(
    parameter int                           WIDTH       = FLOPENR_DEFAULT_WIDTH,
    parameter logic [FLOPENR_MAX_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             reset,
    input  logic             clk,
    input  logic [WIDTH-1:0] D,
    input  logic             E,
    output logic [WIDTH-1:0] Q
`ifdef FLOPENR_SCLR_EN
    ,
    input  logic             sclr
`endif
);

    localparam logic [FLOPENR_MAX_WIDTH-1:0] RV =
        fit_reset(RESET_VALUE, WIDTH);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        flopenr_bit u_bit (
            .reset (reset),
            .clk   (clk),
            .d     (D[i]),
            .e     (E),
            .rv    (RV[i]),
            .q     (Q[i])
`ifdef FLOPENR_SCLR_EN
            ,
            .sclr  (sclr)
`endif
        );
    end

endmodule

// File: tb/tb_flopenr_reg.sv
// Scoreboard bench for flopenr_reg: 1-bit, 8-bit A5-reset and 8-bit zero-reset.
// Exercises sclr only when FLOPENR_SCLR_EN is defined.
module tb_flopenr_reg;

    typedef struct {
        logic       m1;
        logic [7:0] m8;
        logic [7:0] mz;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       d1;
    logic       e1;
    logic       q1;
    logic [7:0] d8;
    logic       e8;
    logic [7:0] q8;
    logic [7:0] qz;
`ifdef FLOPENR_SCLR_EN
    logic       sclr;
`endif

    int   n_checks;
    int   n_pass;
    exp_t sb[$];
    exp_t cur;
    bit   known;

    flopenr_reg #(.WIDTH(1)) u_w1 (
        .reset (reset),
        .clk   (clk),
        .D     (d1),
        .E     (e1),
        .Q     (q1)
`ifdef FLOPENR_SCLR_EN
        ,
        .sclr  (sclr)
`endif
    );

    flopenr_reg #(.WIDTH(8), .RESET_VALUE(64'hA5)) u_w8 (
        .reset (reset),
        .clk   (clk),
        .D     (d8),
        .E     (e8),
        .Q     (q8)
`ifdef FLOPENR_SCLR_EN
        ,
        .sclr  (sclr)
`endif
    );

    flopenr_reg #(.WIDTH(8)) u_wz (
        .reset (reset),
        .clk   (clk),
        .D     (d8),
        .E     (e8),
        .Q     (qz)
`ifdef FLOPENR_SCLR_EN
        ,
        .sclr  (sclr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic stable_checks(input string ph);
        if (known) begin
            check({"q1 ", ph}, {7'd0, q1}, {7'd0, cur.m1});
            check({"q8 ", ph}, q8, cur.m8);
            check({"qz ", ph}, qz, cur.mz);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input logic r, input logic sc,
                         input logic dd1, input logic ee1,
                         input logic [7:0] dd8, input logic ee8);
        exp_t nx;
        exp_t got;
        reset = r;
        d1    = dd1;
        e1    = ee1;
        d8    = dd8;
        e8    = ee8;
`ifdef FLOPENR_SCLR_EN
        sclr  = sc;
`endif
        nx = cur;
        if (r || sc) begin
            nx.m1 = 1'b0;
            nx.m8 = 8'hA5;
            nx.mz = 8'h00;
        end else begin
            if (ee1) nx.m1 = dd1;
            if (ee8) begin
                nx.m8 = dd8;
                nx.mz = dd8;
            end
        end
        sb.push_back(nx);
        #4;
        stable_checks("mid-high");
        #6;
        #1;
        stable_checks("fall");
        #4;
        stable_checks("mid-low");
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard empty", 8'h01, 8'h00);
        end else begin
            got = sb.pop_front();
            check("q1 edge", {7'd0, q1}, {7'd0, got.m1});
            check("q8 edge", q8, got.m8);
            check("qz edge", qz, got.mz);
            cur   = got;
            known = 1'b1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        known    = 1'b0;
        cur      = '{m1: 1'b0, m8: 8'h00, mz: 8'h00};
        reset    = 1'b1;
        d1       = 1'b0;
        e1       = 1'b0;
        d8       = 8'h00;
        e8       = 1'b0;
`ifdef FLOPENR_SCLR_EN
        sclr     = 1'b0;
`endif
        @(posedge clk);
        #1;
        // reset with enable low
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
        // enable low, D high: hold
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
        // load
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
        // hold 3C with D=FF
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
        // reset overrides enable
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1);
        // tracking with E held high
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b0, 1'($urandom_range(1)), 1'b1,
                  8'($urandom_range(255)), 1'b1);
        // D toggling with E low
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 1'(i % 2), 1'b0,
                  (i % 2 == 1) ? 8'hAA : 8'h55, 1'b0);
`ifdef FLOPENR_SCLR_EN
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h42, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h42, 1'b0);
`endif
        // final load and reset
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
